// File: rtl/traffic_input_conditioner.sv
// Input conditioning for the traffic light controller: synchronizes and
// debounces loop detectors and pedestrian buttons, stretches presence, latches requests.
module traffic_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic n_det_raw,
    input  logic s_det_raw,
    input  logic e_det_raw,
    input  logic w_det_raw,
    input  logic ns_btn_raw,
    input  logic ew_btn_raw,
    input  logic ns_walk,
    input  logic ew_walk,
    output logic N_Sensor,
    output logic S_Sensor,
    output logic E_Sensor,
    output logic W_Sensor,
    output logic NS_pedestrian_button,
    output logic EW_pedestrian_button,
    output logic ns_wait_lamp,
    output logic ew_wait_lamp
);

    localparam int MAXC = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DB_LIM  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SERVING
    } ped_state_t;

    logic [5:0]    raw;
    logic [5:0]    sync1;
    logic [5:0]    sync2;
    logic [5:0]    db;
    logic [5:0]    db_nx;
    logic [5:0]    rise;
    logic [3:0]    fall;
    logic [3:0]    sens_nx;
    logic [3:0]    sens_q;
    logic [1:0]    walk;
    logic [1:0]    req_nx;
    logic [1:0]    req_q;
    logic [CW-1:0] cnt     [6];
    logic [CW-1:0] cnt_nx  [6];
    logic [CW-1:0] hold    [4];
    logic [CW-1:0] hold_nx [4];
    ped_state_t    ped_st  [2];
    ped_state_t    ped_nx  [2];

    // channels 0..3 are N/S/E/W detectors, 4..5 are NS/EW buttons
    assign raw  = {ew_btn_raw, ns_btn_raw, w_det_raw, e_det_raw, s_det_raw, n_det_raw};
    assign walk = {ew_walk, ns_walk};

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            db_nx[i]  = db[i];
            cnt_nx[i] = '0;
            if (sync2[i] != db[i]) begin
                if (cnt[i] + ONE == DB_LIM) begin
                    db_nx[i] = sync2[i];
                end else begin
                    cnt_nx[i] = cnt[i] + ONE;
                end
            end
        end
        rise = db_nx & ~db;
        fall = db[3:0] & ~db_nx[3:0];
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hold_nx[i] = (hold[i] == '0) ? '0 : hold[i] - ONE;
            if (fall[i]) begin
                hold_nx[i] = HOLD_LD;
            end
            if (rise[i]) begin
                hold_nx[i] = '0;
            end
            sens_nx[i] = db_nx[i] | (hold_nx[i] != '0);
        end
    end

    // walk is only an acknowledge; it never starts a request
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            ped_nx[j] = ped_st[j];
            unique case (ped_st[j])
                IDLE:    if (rise[4+j]) ped_nx[j] = PENDING;
                PENDING: if (walk[j])   ped_nx[j] = SERVING;
                SERVING: if (!walk[j])  ped_nx[j] = IDLE;
                default: ped_nx[j] = IDLE;
            endcase
            req_nx[j] = (ped_nx[j] == PENDING);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            sens_q <= '0;
            req_q  <= '0;
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            for (int j = 0; j < 2; j++) ped_st[j] <= IDLE;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            db     <= db_nx;
            sens_q <= sens_nx;
            req_q  <= req_nx;
            for (int i = 0; i < 6; i++) cnt[i] <= cnt_nx[i];
            for (int i = 0; i < 4; i++) hold[i] <= hold_nx[i];
            for (int j = 0; j < 2; j++) ped_st[j] <= ped_nx[j];
        end
    end

    assign N_Sensor             = sens_q[0];
    assign S_Sensor             = sens_q[1];
    assign E_Sensor             = sens_q[2];
    assign W_Sensor             = sens_q[3];
    assign NS_pedestrian_button = req_q[0];
    assign EW_pedestrian_button = req_q[1];
    assign ns_wait_lamp         = req_q[0];
    assign ew_wait_lamp         = req_q[1];

endmodule

// File: doc/traffic_input_conditioner.md
# traffic_input_conditioner

Front-end conditioning block feeding the traffic light controller's inputs. It synchronizes and debounces the four raw vehicle loop detectors and the two raw pedestrian push-buttons. Each vehicle presence signal is stretched by a hold timer. Each pedestrian press is latched as a pending request until the controller acknowledges it through its pedestrian walk signal. Sits between board I/O and the controller, on the same clock.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must disagree with its debounced level before the debounced level flips; legal range >= 1.
- HOLD_CYCLES, 8: cycles a vehicle sensor output stays high after its debounced detector falls; 0 allowed (no stretch).

Ports:
- clk  in  1  system clock; clock clk.
- reset  in  1  reset reset, asynchronous, active-high.
- n_det_raw, s_det_raw, e_det_raw, w_det_raw  in  1 each  raw asynchronous loop detectors, high = vehicle.
- ns_btn_raw, ew_btn_raw  in  1 each  raw asynchronous pedestrian buttons, high = pressed.
- ns_walk, ew_walk  in  1 each  controller pedestrian signals, synchronous to clk; act as request acknowledge.
- N_Sensor, S_Sensor, E_Sensor, W_Sensor  out  1 each  conditioned vehicle presence, registered.
- NS_pedestrian_button, EW_pedestrian_button  out  1 each  latched pedestrian request, registered.
- ns_wait_lamp, ew_wait_lamp  out  1 each  "request registered" indicator, equal to the corresponding request output.

## Operation

- Synchronizer: a 2-flop chain on each of the six raw inputs. ns_walk and ew_walk are not synchronized.
- Debouncer, one per synchronized input:
  - Holds a debounced level db and a counter.
  - Counter increments while sync != db; it clears to 0 on any cycle where sync == db.
  - When the counter would reach DEBOUNCE_CYCLES, db takes the value of sync and the counter clears.
  - Counter width is internal, sized for max(DEBOUNCE_CYCLES, HOLD_CYCLES) with no overflow.
- Vehicle stretch, per detector:
  - A hold counter loads HOLD_CYCLES on a db falling edge and decrements by 1 to 0, saturating at 0.
  - A db rising edge clears the hold counter.
  - Sensor output = db OR (hold != 0).
- Pedestrian request FSM, one per direction; states IDLE, PENDING, SERVING:
  - IDLE -> PENDING on a db rising edge of the button. Walk input is ignored in IDLE.
  - PENDING -> SERVING when walk == 1 is sampled.
  - SERVING -> IDLE when walk == 0 is sampled.
  - Request output and wait lamp are high only in PENDING.
  - Button rising edges in PENDING or SERVING are ignored; requests never queue.
  - A button held continuously does not re-request after SERVING -> IDLE. A new db rising edge is required.

## Timing

- Reset (asynchronous, any time):
  - All sync flops, db levels, counters, and outputs go to 0.
  - Both FSMs go to IDLE; a pending request is dropped.
  - The first raw high after release is treated as a new edge.
- Edge 1 is the first rising edge sampling a new stable raw value. The debounced level flips at edge 2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
- Sensor rise is on the same edge db rises, i.e. edge 2+DEBOUNCE_CYCLES.
- Sensor fall is at edge 2+DEBOUNCE_CYCLES+HOLD_CYCLES after the raw fall. With HOLD_CYCLES = 0 it falls on the same edge as db.
- A detector re-rise during the hold keeps the sensor high continuously, with no low cycle.
- Request rises on the same edge the button db rises.
- Request falls on the edge that samples walk == 1. SERVING -> IDLE occurs on the first edge sampling walk == 0.
- If the button db rising edge and walk == 1 coincide in IDLE, the FSM enters PENDING and the request rises.
- Outputs change only on clk edges, except for asynchronous reset.

## Test plan

Defaults throughout: DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 8.

- Reset check: assert reset mid-stream with a request PENDING -> all outputs 0 immediately. After release with inputs low, outputs stay 0 for 20 cycles.
- Debounce: n_det_raw high for 3 cycles then low -> N_Sensor stays 0. n_det_raw held high -> N_Sensor rises at edge 6 and no earlier.
- Hold stretch: e_det_raw falls after N_Sensor-style settling -> E_Sensor falls at edge 14 after the raw fall. Re-raise within 5 cycles of the fall -> E_Sensor never drops.
- Pedestrian handshake:
  - ns_btn_raw pressed for 10 cycles -> NS_pedestrian_button and ns_wait_lamp rise at edge 6 and stay high with ns_walk = 0 for 50 cycles.
  - Drive ns_walk = 1 for 1 cycle -> request falls on that edge.
  - ns_walk back to 0 -> FSM returns to IDLE.
- No re-request: button held through the whole handshake -> no second request. Release, then press again -> new request at edge 6 of the new press.
- Independence: simultaneous EW press and all four detectors high -> all outputs rise on the same edge 6. ew_walk = 1 while in IDLE has no effect.
